// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  // Default word/line geometry (32-bit words, four words per L1 line).
  localparam int DEF_ADDR_W          = 32;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_WORDS_PER_BLOCK = 4;

  localparam int BYTES_PER_WORD    = DEF_DATA_W / 8;
  localparam int BLOCK_BYTES       = BYTES_PER_WORD * DEF_WORDS_PER_BLOCK;
  localparam int BLOCK_OFFSET_BITS = $clog2(BLOCK_BYTES);

  // Arbiter FSM states; the encoding is also exported on dbg_state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IFILL = 3'd1,
    ST_DATA  = 3'd2,
    ST_IDONE = 3'd3,
    ST_DDONE = 3'd4
  } arb_state_e;

  // Which requester was served most recently (round-robin history).
  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  // Byte offset bits inside one line for a given geometry.
  function automatic int block_offset_bits(input int data_w, input int words_per_block);
    return $clog2((data_w / 8) * words_per_block);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-ported main-memory sequencer shared by L1 I-cache refills
// (multi-beat line read) and the CPU data port (single-word read/write).
//
// Handshake: requesters hold a level request (if_miss, d_read, d_write)
// until their one-cycle done pulse (delivered, d_valid) and must drop it in
// that cycle. Toward memory, m_req/m_we/m_addr/m_wdata stay constant while
// m_req is high until the cycle m_ack is seen; that cycle completes the beat
// and m_rdata is valid in it. Wait states are unbounded.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          if_miss,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          delivered,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] blockout,
  input  logic                          d_read,
  input  logic                          d_write,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_valid,
  output logic                          m_req,
  output logic                          m_we,
  output logic [ADDR_W-1:0]             m_addr,
  output logic [DATA_W-1:0]             m_wdata,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic                          m_ack,
  output logic                          busy,
  output logic [2:0]                    dbg_state
);

  localparam int BPW         = DATA_W / 8;
  localparam int WORD_OFF    = $clog2(BPW);
  localparam int BLK_OFF     = block_offset_bits(DATA_W, WORDS_PER_BLOCK);
  localparam int BEAT_W      = $clog2(WORDS_PER_BLOCK);
  localparam int BLK_W       = DATA_W * WORDS_PER_BLOCK;

  localparam logic [ADDR_W-1:0] BLK_MASK  = ~((ADDR_W'(1) << BLK_OFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WORD_MASK = ~((ADDR_W'(1) << WORD_OFF) - ADDR_W'(1));
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);

  arb_state_e          state_q, state_d;
  grant_e              last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                d_req;
  logic                pick_instr;
  logic [ADDR_W-1:0]   beat_off;

  assign d_req    = d_read | d_write;
  // On a tie the requester not served last wins; otherwise whoever asks.
  assign pick_instr = (if_miss && d_req) ? (last_grant_q == GNT_DATA) : if_miss;
  assign beat_off = ADDR_W'(beat_q) << WORD_OFF;

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_DATA;
      beat_q       <= '0;
      base_q       <= '0;
      daddr_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      blk_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      daddr_q      <= daddr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      blk_q        <= blk_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state: grant in IDLE, beat sequencing, capture of returned data.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    base_d       = base_q;
    daddr_d      = daddr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    blk_d        = blk_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_miss || d_req) begin
          if (pick_instr) begin
            state_d = ST_IFILL;
            base_d  = if_addr & BLK_MASK;
            beat_d  = '0;
          end else begin
            state_d = ST_DATA;
            daddr_d = d_addr & WORD_MASK;
            wdata_d = d_wdata;
            // A simultaneous read and write is taken as a write.
            we_d    = d_write;
          end
        end
      end
      ST_IFILL: begin
        if (m_ack) begin
          blk_d[beat_q*DATA_W +: DATA_W] = m_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_IDONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (m_ack) begin
          if (!we_q) begin
            rdata_d = m_rdata;
          end
          state_d = ST_DDONE;
        end
      end
      ST_IDONE: begin
        last_grant_d = GNT_INSTR;
        state_d      = ST_IDLE;
      end
      ST_DDONE: begin
        last_grant_d = GNT_DATA;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory-side and requester-side outputs decoded from the current state.
  always_comb begin
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    delivered = 1'b0;
    d_valid   = 1'b0;
    case (state_q)
      ST_IFILL: begin
        m_req  = 1'b1;
        m_addr = base_q + beat_off;
      end
      ST_DATA: begin
        m_req   = 1'b1;
        m_we    = we_q;
        m_addr  = daddr_q;
        m_wdata = wdata_q;
      end
      ST_IDONE: delivered = 1'b1;
      ST_DDONE: d_valid   = 1'b1;
      default: ;
    endcase
  end

  assign blockout  = blk_q;
  assign d_rdata   = rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small zero/N-wait memory model.
module tb_mem_port_arbiter;

  logic          clk;
  logic          rst;
  logic          if_miss;
  logic [31:0]   if_addr;
  logic          delivered;
  logic [127:0]  blockout;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          m_req;
  logic          m_we;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          m_ack;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int wait_n   = 0;
  int wcnt;
  int cyc;

  logic          wr_valid = 1'b0;
  logic [31:0]   wr_addr  = '0;
  logic [31:0]   wr_data  = '0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_miss   (if_miss),
    .if_addr   (if_addr),
    .delivered (delivered),
    .blockout  (blockout),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks after wait_n wait cycles; unwritten words read as their address.
  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (m_req && !m_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (m_req && m_ack && m_we) begin
      wr_valid <= 1'b1;
      wr_addr  <= m_addr;
      wr_data  <= m_wdata;
    end
  end

  always_comb begin
    m_ack   = 1'b0;
    m_rdata = '0;
    if (m_req) begin
      m_ack   = (wcnt == wait_n);
      m_rdata = (wr_valid && m_addr == wr_addr) ? wr_data : m_addr;
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    if_miss = 1'b0;
    if_addr = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    wait_n  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mreq", m_req, 0);
    chk("rst_blk", blockout, 0);
    chk("rst_rdata", d_rdata, 0);
    chk("rst_pulses", {delivered, d_valid}, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // Steps until delivered, bounded; returns -1 on timeout.
  task automatic wait_delivered(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (delivered) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    do_reset();

    // Isolated refill, zero wait states
    if_miss = 1'b1;
    if_addr = 32'h0000_1234;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("rf_req", m_req, 1);
      chk("rf_we", m_we, 0);
      chk("rf_addr", m_addr, 32'h1230 + 4 * (c - 1));
      chk("rf_early_dlv", delivered, 0);
    end
    step();
    chk("rf_dlv", delivered, 1);
    chk("rf_blk", blockout, 128'h0000123C_00001238_00001234_00001230);
    if_miss = 1'b0;
    step();
    chk("rf_pulse_end", delivered, 0);
    chk("rf_idle", busy, 0);

    // Write then read
    d_write = 1'b1;
    d_addr  = 32'h0000_2002;
    d_wdata = 32'hDEAD_BEEF;
    step();
    chk("wr_req", m_req, 1);
    chk("wr_we", m_we, 1);
    chk("wr_addr", m_addr, 32'h2000);
    chk("wr_wdata", m_wdata, 32'hDEAD_BEEF);
    step();
    chk("wr_valid", d_valid, 1);
    d_write = 1'b0;
    step();
    chk("wr_pulse_end", d_valid, 0);
    d_read = 1'b1;
    d_addr = 32'h0000_2000;
    step();
    chk("rd_we", m_we, 0);
    chk("rd_addr", m_addr, 32'h2000);
    step();
    chk("rd_valid", d_valid, 1);
    chk("rd_data", d_rdata, 32'hDEAD_BEEF);
    chk("blk_hold", blockout, 128'h0000123C_00001238_00001234_00001230);
    d_read = 1'b0;
    step();

    // Read and write together is a write
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_2013;
    d_wdata = 32'h1234_5678;
    step();
    chk("rw_we", m_we, 1);
    chk("rw_addr", m_addr, 32'h2010);
    step();
    chk("rw_valid", d_valid, 1);
    chk("rw_rdata_hold", d_rdata, 32'hDEAD_BEEF);
    d_read  = 1'b0;
    d_write = 1'b0;
    step();

    // Data request arriving at refill beat 2
    if_miss = 1'b1;
    if_addr = 32'h0000_0708;
    step();
    chk("mid_addr1", m_addr, 32'h700);
    step();
    chk("mid_addr2", m_addr, 32'h704);
    d_read = 1'b1;
    d_addr = 32'h0000_0304;
    step();
    chk("mid_addr3", m_addr, 32'h708);
    step();
    chk("mid_addr4", m_addr, 32'h70C);
    step();
    chk("mid_dlv", delivered, 1);
    chk("mid_noreq", m_req, 0);
    if_miss = 1'b0;
    step();
    chk("mid_idle", busy, 0);
    chk("mid_idle_req", m_req, 0);
    step();
    chk("mid_data_req", m_req, 1);
    chk("mid_data_addr", m_addr, 32'h304);
    step();
    chk("mid_data_valid", d_valid, 1);
    chk("mid_data_rdata", d_rdata, 32'h304);
    d_read = 1'b0;
    step();

    // Wait states: ack on third cycle of each beat
    wait_n  = 2;
    if_miss = 1'b1;
    if_addr = 32'h0000_4010;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("ws_req", m_req, 1);
      chk("ws_addr", m_addr, 32'h4010 + 4 * ((c - 1) / 3));
      chk("ws_early_dlv", delivered, 0);
    end
    step();
    chk("ws_dlv13", delivered, 1);
    chk("ws_blk", blockout, 128'h0000401C_00004018_00004014_00004010);
    if_miss = 1'b0;
    wait_n  = 0;
    step();

    // Tie after reset: refill first, then the next tie goes to data
    do_reset();
    if_miss = 1'b1;
    if_addr = 32'h0000_0040;
    d_read  = 1'b1;
    d_addr  = 32'h0000_0080;
    step();
    chk("tie1_addr", m_addr, 32'h40);
    chk("tie1_we", m_we, 0);
    repeat (3) step();
    step();
    chk("tie1_dlv", delivered, 1);
    if_miss = 1'b0;
    step();
    chk("tie1_idle", busy, 0);
    if_miss = 1'b1;
    if_addr = 32'h0000_0500;
    step();
    chk("tie2_data_first", m_addr, 32'h80);
    step();
    chk("tie2_valid", d_valid, 1);
    chk("tie2_rdata", d_rdata, 32'h80);
    d_read = 1'b0;
    step();
    chk("tie2_idle", busy, 0);
    step();
    chk("tie2_refill_addr", m_addr, 32'h500);
    wait_delivered(10, cyc);
    chk("tie2_refill_cycles", cyc, 4);
    chk("tie2_blk", blockout, 128'h0000050C_00000508_00000504_00000500);
    if_miss = 1'b0;
    step();

    // Reset mid-refill
    if_miss = 1'b1;
    if_addr = 32'h0000_1234;
    step();
    step();
    step();
    chk("mr_inflight", m_addr, 32'h1238);
    rst = 1'b0;
    #1;
    chk("mr_req", m_req, 0);
    chk("mr_busy", busy, 0);
    chk("mr_blk", blockout, 0);
    if_miss = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    if_miss = 1'b1;
    step();
    chk("mr_restart_addr", m_addr, 32'h1230);
    wait_delivered(10, cyc);
    chk("mr_restart_cycles", cyc, 4);
    chk("mr_blk_new", blockout, 128'h0000123C_00001238_00001234_00001230);
    if_miss = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-ported main memory between two requesters: L1 instruction-cache line refills (multi-beat block read) and the CPU data port (single-word read/write).
- Sits between the L1 instruction cache, the CPU data port and the main-memory array.
- Grants one transaction at a time and arbitrates ties round-robin.
- Assembles refill beats into a cache block, and pulses a completion strobe to each requester.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, memory word width in bits.
- WORDS_PER_BLOCK, 4, words per L1 line; must be a power of two ≥2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- if_miss  in  1  L1 refill request (level); held until delivered.
- if_addr  in  ADDR_W  miss address (any byte within the line).
- delivered  out  1  one-cycle pulse: blockout valid.
- blockout  out  DATA_W*WORDS_PER_BLOCK  refilled line; word k at bits [DATA_W*k +: DATA_W].
- d_read  in  1  data read request (level); held until d_valid.
- d_write  in  1  data write request (level); held until d_valid.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data.
- d_valid  out  1  one-cycle pulse: data transaction complete.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  word-aligned memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid with m_ack.
- m_ack  in  1  memory accepts/completes the current beat this cycle.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, beat=0, last_grant=DATA.
  - All outputs 0, including blockout and d_rdata.
  - Any in-flight transaction is abandoned and m_req drops immediately.
- FSM states: IDLE, IFILL, DATA, IDONE, DDONE.
- IDLE:
  - Only if_miss → IFILL.
  - Only (d_read|d_write) → DATA.
  - Both → grant the requester opposite to last_grant.
  - Grant is registered, so m_req rises the cycle after the request is seen.
- IFILL:
  - base = if_addr with the low log2(WORDS_PER_BLOCK*DATA_W/8) bits cleared, latched on entry.
  - m_req=1, m_we=0, m_addr = base + beat*(DATA_W/8).
  - On m_ack: capture m_rdata into word[beat] and increment beat. After the last beat → IDONE, beat=0.
  - m_addr is stable until m_ack; wait states are unbounded.
- IDONE: delivered=1 for one cycle; last_grant=INSTR; → IDLE.
- DATA:
  - Address, write data and op are latched on entry.
  - m_req=1, m_we=d_write, m_addr=d_addr with bits [1:0] cleared, m_wdata=d_wdata.
  - On m_ack: a read captures m_rdata into d_rdata; → DDONE.
  - d_read and d_write both high → treated as a write.
- DDONE: d_valid=1 for one cycle; last_grant=DATA; → IDLE.
- blockout and d_rdata hold their last value until overwritten by the next transaction of the same kind.
- No preemption: a request arriving mid-transaction waits, and beats of different transactions never interleave.
- A requester dropping its request mid-transaction does not abort it; the done pulse is still issued.
- Requesters must deassert in the cycle of their done pulse. A request still high in IDLE is a new transaction.
- Latency with zero wait states:
  - Refill: m_req cycles 1..WORDS_PER_BLOCK, delivered at cycle WORDS_PER_BLOCK+1 (5 for default).
  - Data: m_req at cycle 1, d_valid at cycle 2.
- Word-only accesses; sub-word sizes are out of scope for this block.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, IFILL, DATA, IDONE, DDONE);
  - grant enum (INSTR, DATA);
  - BYTES_PER_WORD;
  - BLOCK_BYTES;
  - BLOCK_OFFSET_BITS.
- Single module; no sub-module. Beat counter, round-robin pick and block assembly stay inline.

Test Plan:
- Isolated refill:
  - Stimulus: if_miss=1, if_addr=0x00001234; memory acks every cycle with data = address.
  - Response: m_addr 0x1230, 0x1234, 0x1238, 0x123C on cycles 1–4; delivered at cycle 5; blockout = {0x123C, 0x1238, 0x1234, 0x1230}.
- Write then read:
  - Stimulus: d_write, d_addr=0x2002, d_wdata=0xDEADBEEF.
  - Response: m_we=1, m_addr=0x2000, d_valid at cycle 2.
  - Then d_read to 0x2000 → d_rdata=0xDEADBEEF, d_valid pulse.
- Tie after reset:
  - Stimulus: if_miss and d_read asserted together.
  - Response: refill served first, then data; on the next tie, data is served first.
- Data request at refill beat 2:
  - Response: no data address appears on m_addr until after delivered; DATA starts the cycle after IDONE→IDLE.
- Wait states:
  - Stimulus: m_ack asserted on the 3rd cycle of each beat.
  - Response: m_req and m_addr stable while waiting; delivered at cycle 13.
- Reset mid-refill:
  - Stimulus: rst=0 after 2 acked beats.
  - Response: m_req, busy and blockout are 0 immediately. After release, a new miss restarts at beat 0 with the base address.
